// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width and branch predictor counter helpers.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Weakly-taken value: counter MSB set, all lower bits clear.
  function automatic int unsigned pred_cnt_init(input int unsigned cnt_w);
    return 32'd1 << (cnt_w - 1);
  endfunction

  // Saturating step of a cnt_w-bit counter; up=1 counts toward the max.
  function automatic int unsigned pred_cnt_sat(input int unsigned cnt,
                                               input int unsigned cnt_w,
                                               input logic        up);
    int unsigned max_v;
    max_v = (32'd1 << cnt_w) - 32'd1;
    if (up)
      return (cnt >= max_v) ? max_v : cnt + 32'd1;
    else
      return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/pred_counter.sv
// One saturating direction counter; init loads a fresh value on allocation.
module pred_counter
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             taken,
  input  logic             init,
  input  logic [CNT_W-1:0] init_val,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] WT = CNT_W'(pred_cnt_init(CNT_W));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= WT;
    else if (init)
      cnt <= init_val;
    else if (en)
      cnt <= CNT_W'(pred_cnt_sat(32'(cnt), CNT_W, taken));
  end

endmodule

// File: rtl/pred_btb.sv
// Fully-associative BTB with per-entry saturating direction counters.
// Lookup is combinational; branch-unit updates land on the next edge.
module pred_btb
  import riscv_pkg::*;
#(
  parameter int unsigned NB_ENTRIES = 8,
  parameter int unsigned CNT_W      = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            pred_v_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_pc_o,
  input  logic            bu_upd_v_i,
  input  logic [XLEN-1:0] bu_pc_branch_i,
  input  logic [XLEN-1:0] bu_pc_target_i,
  input  logic            bu_taken_i
);

  localparam int unsigned      IDX_W = $clog2(NB_ENTRIES);
  localparam logic [CNT_W-1:0] WT    = CNT_W'(pred_cnt_init(CNT_W));

  logic [NB_ENTRIES-1:0]            valid;
  logic [NB_ENTRIES-1:0][XLEN-1:0]  tag;
  logic [NB_ENTRIES-1:0][XLEN-1:0]  tgt;
  logic [NB_ENTRIES-1:0][CNT_W-1:0] cnt;
  logic [IDX_W-1:0]                 rr_ptr;

  logic [NB_ENTRIES-1:0] look_hit;
  logic [NB_ENTRIES-1:0] upd_hit;
  logic [NB_ENTRIES-1:0] cnt_en;
  logic [NB_ENTRIES-1:0] cnt_init;
  logic                  upd_any_hit;
  logic                  any_inv;
  logic [IDX_W-1:0]      first_inv;
  logic [IDX_W-1:0]      victim;
  logic                  upd_ok;
  logic                  alloc;

  // Lookup: tags are unique among valid entries, so an AND-OR mux suffices.
  always_comb begin
    pred_v_o     = 1'b0;
    pred_taken_o = 1'b0;
    pred_pc_o    = '0;
    for (int i = 0; i < NB_ENTRIES; i++) begin
      look_hit[i]  = if_req_i & valid[i] & (tag[i] == if_pc_i);
      pred_v_o     = pred_v_o | look_hit[i];
      pred_taken_o = pred_taken_o | (look_hit[i] & cnt[i][CNT_W-1]);
      pred_pc_o    = pred_pc_o | ({XLEN{look_hit[i]}} & tgt[i]);
    end
  end

  // Victim: lowest invalid entry, else the round-robin pointer.
  always_comb begin
    any_inv   = 1'b0;
    first_inv = '0;
    for (int i = NB_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        any_inv   = 1'b1;
        first_inv = IDX_W'(i);
      end
    end
    victim = any_inv ? first_inv : rr_ptr;
  end

  always_comb begin
    upd_any_hit = 1'b0;
    for (int i = 0; i < NB_ENTRIES; i++) begin
      upd_hit[i]  = valid[i] & (tag[i] == bu_pc_branch_i);
      upd_any_hit = upd_any_hit | upd_hit[i];
    end
  end

  // Flush wins over a same-cycle update.
  assign upd_ok = bu_upd_v_i & ~flush_i;
  assign alloc  = upd_ok & ~upd_any_hit & bu_taken_i;

  always_comb begin
    for (int i = 0; i < NB_ENTRIES; i++) begin
      cnt_en[i]   = upd_ok & upd_hit[i];
      cnt_init[i] = alloc & (victim == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid  <= '0;
      tag    <= '0;
      tgt    <= '0;
      rr_ptr <= '0;
    end else if (flush_i) begin
      valid  <= '0;
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NB_ENTRIES; i++) begin
        if (cnt_init[i]) begin
          valid[i] <= 1'b1;
          tag[i]   <= bu_pc_branch_i;
          tgt[i]   <= bu_pc_target_i;
        end else if (cnt_en[i] && bu_taken_i) begin
          tgt[i]   <= bu_pc_target_i;
        end
      end
      if (alloc && !any_inv)
        rr_ptr <= rr_ptr + 1'b1;
    end
  end

  for (genvar g = 0; g < NB_ENTRIES; g++) begin : g_cnt
    pred_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (cnt_en[g]),
      .taken    (bu_taken_i),
      .init     (cnt_init[g]),
      .init_val (WT),
      .cnt      (cnt[g])
    );
  end

endmodule

// File: tb/tb_pred_btb.sv
// Self-checking bench for pred_btb: directed plan plus randomized traffic
// against a behavioural entry-table model.
module tb_pred_btb;
  import riscv_pkg::*;

  localparam int NE = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int WTV = 1 << (CW - 1);

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            flush_i = 1'b0;
  logic            if_req_i = 1'b0;
  logic [XLEN-1:0] if_pc_i = '0;
  logic            pred_v_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_pc_o;
  logic            bu_upd_v_i = 1'b0;
  logic [XLEN-1:0] bu_pc_branch_i = '0;
  logic [XLEN-1:0] bu_pc_target_i = '0;
  logic            bu_taken_i = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pred_btb #(.NB_ENTRIES(NE), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush_i        (flush_i),
    .if_req_i       (if_req_i),
    .if_pc_i        (if_pc_i),
    .pred_v_o       (pred_v_o),
    .pred_taken_o   (pred_taken_o),
    .pred_pc_o      (pred_pc_o),
    .bu_upd_v_i     (bu_upd_v_i),
    .bu_pc_branch_i (bu_pc_branch_i),
    .bu_pc_target_i (bu_pc_target_i),
    .bu_taken_i     (bu_taken_i)
  );

  // Behavioural model: a table of entries plus a replacement pointer.
  bit                m_v   [NE];
  logic [XLEN-1:0]   m_tag [NE];
  logic [XLEN-1:0]   m_tgt [NE];
  int                m_cnt [NE];
  int                m_rr;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NE; i++) begin
      m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = WTV;
    end
    m_rr = 0;
  endtask

  task automatic m_look(input logic rq, input logic [XLEN-1:0] pc,
                        output logic v, output logic t, output logic [XLEN-1:0] p);
    v = 0; t = 0; p = '0;
    if (rq)
      for (int i = 0; i < NE; i++)
        if (m_v[i] && m_tag[i] == pc) begin
          v = 1; t = (m_cnt[i] >= WTV); p = m_tgt[i];
        end
  endtask

  task automatic m_update(input logic uv, input logic [XLEN-1:0] bpc,
                          input logic [XLEN-1:0] btgt, input logic tk, input logic fl);
    int hit;
    int vic;
    if (fl) begin
      for (int i = 0; i < NE; i++) m_v[i] = 0;
      m_rr = 0;
      return;
    end
    if (!uv) return;
    hit = -1;
    for (int i = 0; i < NE; i++) if (m_v[i] && m_tag[i] == bpc) hit = i;
    if (hit >= 0) begin
      if (tk) begin
        m_cnt[hit] = (m_cnt[hit] < CMAX) ? m_cnt[hit] + 1 : CMAX;
        m_tgt[hit] = btgt;
      end else begin
        m_cnt[hit] = (m_cnt[hit] > 0) ? m_cnt[hit] - 1 : 0;
      end
    end else if (tk) begin
      vic = -1;
      for (int i = NE - 1; i >= 0; i--) if (!m_v[i]) vic = i;
      if (vic < 0) begin
        vic = m_rr;
        m_rr = (m_rr + 1) % NE;
      end
      m_v[vic] = 1; m_tag[vic] = bpc; m_tgt[vic] = btgt; m_cnt[vic] = WTV;
    end
  endtask

  // One clock: drive, check the lookup against pre-edge model state, advance.
  task automatic cyc(input logic rq, input logic [XLEN-1:0] pc,
                     input logic uv, input logic [XLEN-1:0] bpc, input logic [XLEN-1:0] btgt,
                     input logic tk, input logic fl,
                     output logic v, output logic t, output logic [XLEN-1:0] p);
    logic ev, et;
    logic [XLEN-1:0] ep;
    @(negedge clk);
    if_req_i = rq; if_pc_i = pc;
    bu_upd_v_i = uv; bu_pc_branch_i = bpc; bu_pc_target_i = btgt; bu_taken_i = tk;
    flush_i = fl;
    #1;
    m_look(rq, pc, ev, et, ep);
    v = pred_v_o; t = pred_taken_o; p = pred_pc_o;
    chk("model_v", XLEN'(v), XLEN'(ev));
    chk("model_taken", XLEN'(t), XLEN'(et));
    chk("model_pc", p, ep);
    @(posedge clk);
    m_update(uv, bpc, btgt, tk, fl);
  endtask

  task automatic upd(input logic [XLEN-1:0] bpc, input logic [XLEN-1:0] btgt, input logic tk);
    logic v, t;
    logic [XLEN-1:0] p;
    cyc(1'b0, '0, 1'b1, bpc, btgt, tk, 1'b0, v, t, p);
  endtask

  task automatic look(input string tag, input logic [XLEN-1:0] pc,
                      input logic ev, input logic et, input logic [XLEN-1:0] ep);
    logic v, t;
    logic [XLEN-1:0] p;
    cyc(1'b1, pc, 1'b0, '0, '0, 1'b0, 1'b0, v, t, p);
    chk({tag, "_v"}, XLEN'(v), XLEN'(ev));
    chk({tag, "_taken"}, XLEN'(t), XLEN'(et));
    chk({tag, "_pc"}, p, ep);
  endtask

  initial begin
    logic v, t;
    logic [XLEN-1:0] p;
    m_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    look("rst", 32'h100, 0, 0, '0);

    // Allocation; same-cycle lookup sees old state.
    cyc(1'b1, 32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, v, t, p);
    chk("same_cyc_v", XLEN'(v), '0);
    look("alloc", 32'h100, 1, 1, 32'h200);

    // Saturation: 2 -> 1,0,0 then 1,2,3,3
    upd(32'h100, 32'h999, 1'b0); look("nt1", 32'h100, 1, 0, 32'h200);
    upd(32'h100, 32'h999, 1'b0); look("nt2", 32'h100, 1, 0, 32'h200);
    upd(32'h100, 32'h999, 1'b0); look("nt3", 32'h100, 1, 0, 32'h200);
    upd(32'h100, 32'h200, 1'b1); look("tk1", 32'h100, 1, 0, 32'h200);
    upd(32'h100, 32'h200, 1'b1); look("tk2", 32'h100, 1, 1, 32'h200);
    upd(32'h100, 32'h200, 1'b1); look("tk3", 32'h100, 1, 1, 32'h200);
    upd(32'h100, 32'h200, 1'b1); look("tk4", 32'h100, 1, 1, 32'h200);
    // From saturated 3, a single not-taken must keep MSB set.
    upd(32'h100, 32'h200, 1'b0); look("sat_nt", 32'h100, 1, 1, 32'h200);

    upd(32'h300, 32'h400, 1'b0); look("nt_miss", 32'h300, 0, 0, '0);

    // Eviction order from a clean table.
    @(negedge clk); reset_n = 1'b0; m_reset(); #2 reset_n = 1'b1;
    upd(32'h10, 32'h1010, 1'b1); upd(32'h20, 32'h1020, 1'b1);
    upd(32'h30, 32'h1030, 1'b1); upd(32'h40, 32'h1040, 1'b1);
    look("fill40", 32'h40, 1, 1, 32'h1040);
    upd(32'h50, 32'h1050, 1'b1);
    look("ev10", 32'h10, 0, 0, '0);
    look("hit20", 32'h20, 1, 1, 32'h1020);
    upd(32'h60, 32'h1060, 1'b1);
    look("ev20", 32'h20, 0, 0, '0);
    upd(32'h70, 32'h1070, 1'b1);  // rr_ptr=2 -> evicts 0x30
    look("ev30", 32'h30, 0, 0, '0);
    look("hit40", 32'h40, 1, 1, 32'h1040);

    // Flush beats same-cycle update.
    cyc(1'b0, '0, 1'b1, 32'h700, 32'h800, 1'b1, 1'b1, v, t, p);
    look("fl700", 32'h700, 0, 0, '0);
    look("fl40", 32'h40, 0, 0, '0);
    upd(32'h700, 32'h800, 1'b1);
    look("postfl", 32'h700, 1, 1, 32'h800);
    upd(32'h700, 32'h800, 1'b0);
    look("postfl_nt", 32'h700, 1, 0, 32'h800);

    // Randomized traffic over a small PC pool.
    for (int n = 0; n < 600; n++) begin
      logic [XLEN-1:0] lpc, bpc, btgt;
      lpc  = 32'h1000 + 4 * $urandom_range(0, 7);
      bpc  = 32'h1000 + 4 * $urandom_range(0, 7);
      btgt = 32'h8000 + 4 * $urandom_range(0, 255);
      cyc(1'($urandom_range(0, 3) != 0), lpc, 1'($urandom_range(0, 2) != 0), bpc, btgt,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0), v, t, p);
    end

    // Asynchronous reset mid-cycle.
    upd(32'h900, 32'h904, 1'b1);
    @(negedge clk);
    if_req_i = 1'b1; if_pc_i = 32'h900; bu_upd_v_i = 1'b0; flush_i = 1'b0;
    #1 chk("pre_arst_v", XLEN'(pred_v_o), 32'h1);
    #1 reset_n = 1'b0; m_reset();
    #1 chk("arst_v", XLEN'(pred_v_o), '0);
    chk("arst_pc", pred_pc_o, '0);
    @(negedge clk); reset_n = 1'b1;
    look("post_arst", 32'h900, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
